// File: rtl/mux_nx1_pkg.sv
// Shared defaults and select-width helper for the mux_nx1_buf slice.
// Imported by mux_nx1_buf and sync_fifo.
package mux_nx1_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 11;
    localparam int unsigned DEF_NUM_IN     = 3;
    localparam int unsigned DEF_DEPTH      = 2;

    // Width of the channel index: ceil(log2(num_in)), never less than one bit.
    function automatic int unsigned sel_idx_t(input int unsigned num_in);
        int unsigned w;
        w = 1;
        if (num_in > 2) begin
            w = $unsigned($clog2(num_in));
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_nx1_buf_sync_fifo.sv
// sync_fifo: power-of-two deep synchronous FIFO with occupancy count.
// Storage is not reset; only pointers and level are.
module sync_fifo
    import mux_nx1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (level == LEVEL_W'(DEPTH));
    assign empty = (level == '0);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mux_nx1_buf.sv
// N-to-1 channel selector feeding a small output FIFO with ready/valid handshakes.
// Optional sticky illegal-select flag when MUX_NX1_BUF_SEL_ERR_EN is defined.
module mux_nx1_buf
    import mux_nx1_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_IN     = DEF_NUM_IN,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [sel_idx_t(NUM_IN)-1:0]  select,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         mux_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        level
`ifdef MUX_NX1_BUF_SEL_ERR_EN
    ,
    output logic                          sel_err
`endif
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("mux_nx1_buf: NUM_IN must be in 2..16");
    end

    logic [DATA_WIDTH-1:0] sel_word;
    logic                  accept;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Out-of-range select matches no channel and falls through to zero.
    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(select) == k) begin
                sel_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign in_ready  = !fifo_full || out_ready;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (sel_word),
        .rd_en   (pop),
        .rd_data (mux_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

`ifdef MUX_NX1_BUF_SEL_ERR_EN
    logic select_illegal;

    assign select_illegal = (32'(select) >= NUM_IN);

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && select_illegal) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_buf.sv
// Testbench for mux_nx1_buf: directed scenarios on the default build plus a
// randomized scoreboard run on a NUM_IN=5, DEPTH=4 instance.
module tb_mux_nx1_buf;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [32:0] a_in_data;
    logic [1:0]  a_select;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [10:0] a_mux_out;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [1:0]  a_level;
`ifdef MUX_NX1_BUF_SEL_ERR_EN
    logic        a_sel_err;
    logic        b_sel_err;
`endif

    logic [54:0] b_in_data;
    logic [2:0]  b_select;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [10:0] b_mux_out;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [2:0]  b_level;

    mux_nx1_buf u_dut_a (
        .clock     (clk),
        .reset     (rst),
        .in_data   (a_in_data),
        .select    (a_select),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mux_out   (a_mux_out),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .level     (a_level)
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        ,
        .sel_err   (a_sel_err)
`endif
    );

    mux_nx1_buf #(
        .DATA_WIDTH (11),
        .NUM_IN     (5),
        .DEPTH      (4)
    ) u_dut_b (
        .clock     (clk),
        .reset     (rst),
        .in_data   (b_in_data),
        .select    (b_select),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mux_out   (b_mux_out),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .level     (b_level)
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        ,
        .sel_err   (b_sel_err)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_select = '0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_select = '0; b_in_data = '0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", a_level); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_mux_out !== 11'd0) begin failures++; $display("FAIL reset_mux_out got=%h exp=0", a_mux_out); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (b_level !== 3'd0) begin failures++; $display("FAIL reset_b_level got=%0d exp=0", b_level); end
        checks++; if (b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err got=%b exp=0", a_sel_err); end
`endif
    endtask

    task automatic test_single();
        a_in_data = {11'b11110000010, 11'b00001110001, 11'b0};
        a_select = 2'b01; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", a_in_ready); end
        cyc();
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", a_out_valid); end
        checks++; if (a_mux_out !== 11'b00001110001) begin failures++; $display("FAIL single_mux_out got=%b exp=00001110001", a_mux_out); end
        checks++; if (a_level !== 2'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", a_level); end
        cyc();
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL single_drain_level got=%0d exp=0", a_level); end
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_mux_out !== 11'd0) begin failures++; $display("FAIL single_idle_mux_out got=%h exp=0", a_mux_out); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        a_in_data = {11'b11110000010, 11'b00001110001, 11'b0};
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_select = 2'd0;
        cyc();
        a_select = 2'd1;
        cyc();
        a_select = 2'd2;
        #1;
        checks++; if (a_level !== 2'd2) begin failures++; $display("FAIL bp_level_full got=%0d exp=2", a_level); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full got=%b exp=0", a_in_ready); end
        cyc();
        checks++; if (a_level !== 2'd2) begin failures++; $display("FAIL bp_held_level got=%0d exp=2", a_level); end
        checks++; if (a_mux_out !== 11'd0 || a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_head0 got=%b/%b exp=1/0", a_out_valid, a_mux_out); end
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_pop got=%b exp=1", a_in_ready); end
        cyc();
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_mux_out !== 11'b00001110001) begin failures++; $display("FAIL bp_head1 got=%b exp=00001110001", a_mux_out); end
        checks++; if (a_level !== 2'd2) begin failures++; $display("FAIL bp_level_swap got=%0d exp=2", a_level); end
        cyc();
        checks++; if (a_mux_out !== 11'b11110000010) begin failures++; $display("FAIL bp_head2 got=%b exp=11110000010", a_mux_out); end
        cyc();
        checks++; if (a_out_valid !== 1'b0 || a_level !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", a_out_valid, a_level); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_full_passthrough();
        logic [10:0] w1, w2, w3;
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 33'({$urandom(), $urandom()}); a_select = 2'd1; w1 = a_in_data[11 +: 11];
        cyc();
        a_in_data = 33'({$urandom(), $urandom()}); a_select = 2'd2; w2 = a_in_data[22 +: 11];
        cyc();
        a_in_data = 33'({$urandom(), $urandom()}); a_select = 2'd0; w3 = a_in_data[0 +: 11];
        a_out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (a_mux_out !== w1) begin failures++; $display("FAIL full_head got=%h exp=%h", a_mux_out, w1); end
        cyc();
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_level !== 2'd2) begin failures++; $display("FAIL full_level_kept got=%0d exp=2", a_level); end
        checks++; if (a_mux_out !== w2) begin failures++; $display("FAIL full_next got=%h exp=%h", a_mux_out, w2); end
        cyc();
        checks++; if (a_mux_out !== w3) begin failures++; $display("FAIL full_last got=%h exp=%h", a_mux_out, w3); end
        cyc();
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", a_level); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_illegal_select();
        logic [10:0] w;
        a_in_data = 33'({$urandom(), $urandom()}) | 33'h1;
        a_select = 2'b11; a_in_valid = 1'b1; a_out_ready = 1'b0;
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        #1;
        checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL illegal_err_before got=%b exp=0", a_sel_err); end
`endif
        cyc();
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_level !== 2'd1 || a_out_valid !== 1'b1) begin failures++; $display("FAIL illegal_stored got=%0d/%b exp=1/1", a_level, a_out_valid); end
        checks++; if (a_mux_out !== 11'd0) begin failures++; $display("FAIL illegal_zero_word got=%h exp=0", a_mux_out); end
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b1) begin failures++; $display("FAIL illegal_err_set got=%b exp=1", a_sel_err); end
`endif
        a_in_valid = 1'b1; a_select = 2'd2; a_out_ready = 1'b1; w = a_in_data[22 +: 11];
        cyc();
        a_in_valid = 1'b0;
        #1;
        checks++; if (a_mux_out !== w) begin failures++; $display("FAIL illegal_then_legal got=%h exp=%h", a_mux_out, w); end
        cyc();
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b1) begin failures++; $display("FAIL illegal_err_sticky got=%b exp=1", a_sel_err); end
`endif
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL illegal_drain got=%0d exp=0", a_level); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 33'({$urandom(), $urandom()});
        a_select = 2'd1;
        cyc();
        a_select = 2'd2;
        cyc();
        checks++; if (a_level !== 2'd2) begin failures++; $display("FAIL rmid_prefill got=%0d exp=2", a_level); end
        rst = 1'b1; a_out_ready = 1'b1; a_select = 2'd1;
        cyc();
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_mux_out !== 11'd0) begin failures++; $display("FAIL rmid_mux_out got=%h exp=0", a_mux_out); end
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", a_level); end
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", a_in_ready); end
`ifdef MUX_NX1_BUF_SEL_ERR_EN
        checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL rmid_sel_err got=%b exp=0", a_sel_err); end
`endif
        cyc();
        checks++; if (a_level !== 2'd0) begin failures++; $display("FAIL rmid_dropped got=%0d exp=0", a_level); end
    endtask

    task automatic test_random_wrap();
        logic [10:0] q[$];
        logic [10:0] exp_head;
        logic [10:0] new_word;
        logic        exp_ready, acc, pp;
        int          pops = 0;
        int          cycles = 0;
        int          thresh = 50;
        while (pops < 1000 && cycles < 20000) begin
            if (cycles % 100 == 0) thresh = 20 + 35 * $urandom_range(0, 2);
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_select    = 3'($urandom_range(0, 7));
            b_in_data   = 55'({$urandom(), $urandom()});
            b_out_ready = ($urandom_range(0, 99) < thresh);
            #1;
            exp_ready = (q.size() < 4) || b_out_ready;
            exp_head  = (q.size() != 0) ? q[0] : 11'd0;
            new_word  = (b_select < 5) ? b_in_data[b_select*11 +: 11] : 11'd0;
            checks++; if (b_in_ready !== exp_ready) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cycles, b_in_ready, exp_ready); end
            checks++; if (b_level !== 3'(q.size())) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cycles, b_level, q.size()); end
            checks++; if (b_out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cycles, b_out_valid, q.size() != 0); end
            checks++; if (b_mux_out !== exp_head) begin failures++; $display("FAIL rnd_mux_out cyc=%0d got=%h exp=%h", cycles, b_mux_out, exp_head); end
            acc = b_in_valid && exp_ready;
            pp  = (q.size() != 0) && b_out_ready;
            cyc();
            if (pp) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(new_word);
            cycles++;
        end
        checks++; if (pops != 1000) begin failures++; $display("FAIL rnd_budget got=%0d pops exp=1000", pops); end
        b_in_valid = 1'b0; b_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_passthrough();
        test_illegal_select();
        test_reset_mid();
        test_random_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_buf.md
MUX_NX1_BUF -- requirements
Module: mux_nx1_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 11: width of every data input and the output.
REQ-002 Parameter NUM_IN, default 3: number of input channels, legal range 2..16.
REQ-003 Parameter DEPTH, default 2: output buffer entries, power of two, 2..16.
REQ-004 Derived constant SEL_WIDTH = max(1, ceil(log2(NUM_IN))); DEPTH and NUM_IN outside range SHALL fail elaboration.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_data  input  NUM_IN*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 select  input  SEL_WIDTH  channel index, sampled with in_valid.
REQ-010 in_valid  input  1  producer offers in_data/select this cycle.
REQ-011 in_ready  output  1  block accepts this cycle.
REQ-012 mux_out  output  DATA_WIDTH  head-of-buffer data.
REQ-013 out_valid  output  1  mux_out holds a valid entry.
REQ-014 out_ready  input  1  consumer takes head this cycle.
REQ-015 level  output  ceil(log2(DEPTH))+1  current buffer occupancy.
REQ-016 sel_err  output  1  present only under SEL_ERR_EN (REQ-031).

Function
REQ-017 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 On accept, channel in_data[select] SHALL be written to the tail entry; latency accept-to-out_valid is exactly 1 cycle when the buffer was empty.
REQ-019 select >= NUM_IN (e.g. 2'b11 with NUM_IN=3) SHALL write all-zeros.
REQ-020 in_ready = (level < DEPTH) || out_ready — full buffer SHALL still accept when a pop happens the same cycle.
REQ-021 out_valid = (level != 0); mux_out SHALL equal the head entry and stay stable while out_valid && !out_ready.
REQ-022 When out_valid is low, mux_out SHALL be all-zeros.
REQ-023 Simultaneous accept and pop: level unchanged, entries remain in FIFO order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-025 in_data or select changing without accept SHALL not affect stored entries.
REQ-026 Pop on empty and accept when !in_ready SHALL be ignored.

Reset
REQ-027 On reset high at a clock edge: level=0, pointers=0, out_valid=0, mux_out=0, sel_err=0.
REQ-028 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all buffered entries; an accept coincident with reset SHALL be dropped.
REQ-030 Buffer storage need not be reset; only control state and outputs are.

Configuration
REQ-031 Macro MUX_NX1_BUF_SEL_ERR_EN defined: sel_err port exists; sel_err SHALL assert the cycle after an accept with illegal select and stay high (sticky) until reset.
REQ-032 Macro undefined: sel_err port and its logic are absent; illegal select behaviour per REQ-019 unchanged.

Structure
REQ-033 Package mux_nx1_pkg SHALL hold DATA_WIDTH/NUM_IN/DEPTH defaults and a sel_idx_t helper function computing SEL_WIDTH.
REQ-034 Sub-module sync_fifo (DATA_WIDTH, DEPTH) SHALL implement storage, pointers and level; the top holds the combinational selector and error flag.

Verification
REQ-035 Defaults, in_data={11'b11110000010,11'b00001110001,11'b0}, select=01, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, mux_out=11'b00001110001, then level returns to 0.
REQ-036 out_ready=0, accept selects 00,01,10 in turn -> after 2 accepts level=2, in_ready=0, third offer held; raise out_ready -> outputs 0, 11'b00001110001, 11'b11110000010 in order.
REQ-037 Full buffer, in_valid=1 and out_ready=1 same cycle -> accept and pop both occur, level stays 2.
REQ-038 Accept select=11 -> stored word 0; with macro, sel_err=1 next cycle and remains 1 until reset.
REQ-039 Reset asserted with level=2 -> next cycle out_valid=0, mux_out=0, level=0, in_ready=1.
REQ-040 Random backpressure, NUM_IN=5, DEPTH=4, 1000 transfers -> output sequence matches scoreboard, no loss or duplication across pointer wrap.
